// File: rtl/mult_sched.sv
// Round-robin front end for one shared iterative 32x32 signed multiplier.
// One operation in flight at a time; a watchdog turns a hung multiplier into an error response.
module mult_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_mlier,
  input  logic [32*NREQ-1:0]   req_mcand,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_prodt,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [31:0]          mul_mlier,
  output logic [31:0]          mul_mcand,
  input  logic [63:0]          mul_prodt,
  input  logic                 mul_valid
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [IDW-1:0]    last_reg, last_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0]    rsp_id_reg, rsp_id_next;
  logic [63:0]       rsp_prodt_reg, rsp_prodt_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              mul_start_reg, mul_start_next;
  logic [31:0]       mul_mlier_reg, mul_mlier_next;
  logic [31:0]       mul_mcand_reg, mul_mcand_next;

  logic [31:0]       mlier_arr [NREQ];
  logic [31:0]       mcand_arr [NREQ];

  logic              win_found;
  logic [IDW-1:0]    win_id;
  logic [31:0]       win_mlier;
  logic [31:0]       win_mcand;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign mlier_arr[gi] = req_mlier[32*gi +: 32];
    assign mcand_arr[gi] = req_mcand[32*gi +: 32];
  end

  // Search starts just after the last winner and wraps, so each requester waits at most NREQ-1 turns.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_mlier = '0;
    win_mcand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && req[j] && (((int'(last_reg) + k) % NREQ) == j)) begin
          win_found = 1'b1;
          win_id    = IDW'(j);
          win_mlier = mlier_arr[j];
          win_mcand = mcand_arr[j];
        end
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    cnt_next       = cnt_reg;
    gnt_next       = '0;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id_reg;
    rsp_prodt_next = rsp_prodt_reg;
    rsp_err_next   = rsp_err_reg;
    mul_start_next = mul_start_reg;
    mul_mlier_next = mul_mlier_reg;
    mul_mcand_next = mul_mcand_reg;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next     = RUN;
          last_next      = win_id;
          cnt_next       = '0;
          mul_start_next = 1'b1;
          mul_mlier_next = win_mlier;
          mul_mcand_next = win_mcand;
          for (int j = 0; j < NREQ; j++) begin
            gnt_next[j] = (win_id == IDW'(j));
          end
        end
      end
      RUN: begin
        // A product arriving on the last watchdog cycle still wins over the timeout.
        if (mul_valid) begin
          state_next     = DONE;
          rsp_valid_next = 1'b1;
          rsp_id_next    = last_reg;
          rsp_prodt_next = mul_prodt;
          rsp_err_next   = 1'b0;
          mul_start_next = 1'b0;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          state_next     = DONE;
          rsp_valid_next = 1'b1;
          rsp_id_next    = last_reg;
          rsp_prodt_next = '0;
          rsp_err_next   = 1'b1;
          mul_start_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        mul_start_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_reg      <= IDW'(NREQ - 1);
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_prodt_reg <= '0;
      rsp_err_reg   <= 1'b0;
      mul_start_reg <= 1'b0;
      mul_mlier_reg <= '0;
      mul_mcand_reg <= '0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      cnt_reg       <= cnt_next;
      gnt_reg       <= gnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_prodt_reg <= rsp_prodt_next;
      rsp_err_reg   <= rsp_err_next;
      mul_start_reg <= mul_start_next;
      mul_mlier_reg <= mul_mlier_next;
      mul_mcand_reg <= mul_mcand_next;
    end
  end

  assign gnt       = gnt_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_prodt = rsp_prodt_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = (state_reg != IDLE);
  assign mul_start = mul_start_reg;
  assign mul_mlier = mul_mlier_reg;
  assign mul_mcand = mul_mcand_reg;

endmodule
